// File: rtl/ccta_driver.sv
// Streams buffered operand triples into the combinational CCTA block, holds each
// one for a settle window, samples q and hands it downstream over valid/ready.
module ccta_driver #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] in_c,
    input  logic       in_ctrl,
    output logic [3:0] ccta_a,
    output logic [3:0] ccta_b,
    output logic [3:0] ccta_c,
    output logic       ccta_ctrl,
    input  logic [4:0] ccta_q,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_q,
    output logic       res_ctrl,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [CW-1:0] countQ, countD;
    logic [1:0]    stateQ, stateD;
    logic [HW-1:0] holdQ, holdD;
    logic [12:0]   driveQ, driveD;
    logic [4:0]    resDataQ, resDataD;
    logic          resCtrlQ, resCtrlD;
    logic          resValidQ, resValidD;
    logic          push, pop;

    assign in_ready = (countQ != CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtrQ] <= {in_ctrl, in_a, in_b, in_c};
        end
    end

    // Popping straight from OUTPUT into the drive registers avoids an idle bubble.
    always_comb begin
        stateD    = stateQ;
        holdD     = holdQ;
        driveD    = driveQ;
        resDataD  = resDataQ;
        resCtrlD  = resCtrlQ;
        resValidD = resValidQ;
        pop       = 1'b0;
        case (stateQ)
            IDLE: begin
                if (countQ != '0) begin
                    pop    = 1'b1;
                    driveD = mem[rdPtrQ];
                    holdD  = HW'(HOLD - 1);
                    stateD = APPLY;
                end
            end
            APPLY: begin
                if (holdQ == '0) begin
                    resDataD  = ccta_q;
                    resCtrlD  = driveQ[12];
                    resValidD = 1'b1;
                    stateD    = OUTPUT;
                end else begin
                    holdD = holdQ - HW'(1);
                end
            end
            OUTPUT: begin
                if (resValidQ && res_ready) begin
                    resValidD = 1'b0;
                    if (countQ != '0) begin
                        pop    = 1'b1;
                        driveD = mem[rdPtrQ];
                        holdD  = HW'(HOLD - 1);
                        stateD = APPLY;
                    end else begin
                        stateD = IDLE;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        wrPtrD = wrPtrQ + AW'(push);
        rdPtrD = rdPtrQ + AW'(pop);
        countD = countQ + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            countQ    <= '0;
            holdQ     <= '0;
            driveQ    <= '0;
            resDataQ  <= '0;
            resCtrlQ  <= 1'b0;
            resValidQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            countQ    <= countD;
            holdQ     <= holdD;
            driveQ    <= driveD;
            resDataQ  <= resDataD;
            resCtrlQ  <= resCtrlD;
            resValidQ <= resValidD;
        end
    end

    assign ccta_ctrl = driveQ[12];
    assign ccta_a    = driveQ[11:8];
    assign ccta_b    = driveQ[7:4];
    assign ccta_c    = driveQ[3:0];
    assign res_q     = resDataQ;
    assign res_ctrl  = resCtrlQ;
    assign res_valid = resValidQ;
    assign busy      = (stateQ != IDLE);
endmodule

// File: tb/tb_ccta_driver.sv
// Scoreboard bench for ccta_driver with a behavioural CCTA stub
// (q = A+B when ctrl=0, q = B+C when ctrl=1).
module tb_ccta_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] in_a, in_b, in_c;
    logic       in_ctrl;
    logic [3:0] ccta_a, ccta_b, ccta_c;
    logic       ccta_ctrl;
    logic [4:0] ccta_q;
    logic       res_valid, res_ready;
    logic [4:0] res_q;
    logic       res_ctrl;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [5:0] expQ [$];
    int         resCyc [$];
    logic [5:0] monExp;

    ccta_driver #(.DEPTH(4), .HOLD(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_ctrl(in_ctrl),
        .ccta_a(ccta_a), .ccta_b(ccta_b), .ccta_c(ccta_c), .ccta_ctrl(ccta_ctrl),
        .ccta_q(ccta_q),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_ctrl(res_ctrl), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ccta_q = ccta_ctrl ? ({1'b0, ccta_b} + {1'b0, ccta_c})
                              : ({1'b0, ccta_a} + {1'b0, ccta_b});

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("res_q", int'(res_q), int'(monExp[4:0]));
                checkOutput("res_ctrl", int'(res_ctrl), int'(monExp[5]));
                resCyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                 input logic ctrl, input logic [4:0] q);
        int n;
        in_a = a; in_b = b; in_c = c; in_ctrl = ctrl; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) checkOutput("in_ready_timeout", 0, 1);
        expQ.push_back({ctrl, q});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checkOutput("drain_pending", expQ.size(), 0);
    endtask

    logic [3:0] fa [7] = '{4'h1, 4'h2, 4'h7, 4'h9, 4'hF, 4'h8, 4'h0};
    logic [3:0] fb [7] = '{4'h2, 4'h3, 4'h8, 4'h9, 4'hF, 4'h1, 4'h6};
    logic [3:0] fc [7] = '{4'h3, 4'h4, 4'h9, 4'h1, 4'h0, 4'h1, 4'h6};
    logic       fk [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] fq [7] = '{5'h03, 5'h07, 5'h0F, 5'h0A, 5'h1E, 5'h09, 5'h0C};

    initial begin
        int accepted;
        int idx;
        int n;

        rst = 1'b1; in_valid = 1'b1; in_a = 4'h5; in_b = 4'h5; in_c = 4'h5;
        in_ctrl = 1'b0; res_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ccta_abc", {ccta_a, ccta_b, ccta_c}, 0);
        checkOutput("rst_ccta_ctrl", ccta_ctrl, 0);
        checkOutput("rst_res_q", res_q, 0);
        checkOutput("rst_res_ctrl", res_ctrl, 0);
        repeat (5) tick();
        checkOutput("rst_nothing_stored_busy", busy, 0);
        checkOutput("rst_nothing_stored_valid", res_valid, 0);

        $display("[TB] single triple latency");
        in_a = 4'h4; in_b = 4'h1; in_c = 4'h9; in_ctrl = 1'b0; in_valid = 1'b1;
        expQ.push_back({1'b0, 5'h05});
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("single_ccta_a", ccta_a, 4'h4);
        checkOutput("single_ccta_c", ccta_c, 4'h9);
        checkOutput("single_valid_e1", res_valid, 0);
        tick();
        checkOutput("single_valid_e2", res_valid, 0);
        tick();
        checkOutput("single_valid_e3", res_valid, 1);
        checkOutput("single_res_q_e3", res_q, 5'h05);
        tick();
        checkOutput("single_valid_e4", res_valid, 0);
        checkOutput("single_busy_e4", busy, 0);
        checkOutput("single_drained", expQ.size(), 0);

        $display("[TB] back-to-back");
        resCyc.delete();
        applyStimulus(4'h3, 4'hD, 4'hD, 1'b0, 5'h10);
        applyStimulus(4'h5, 4'h2, 4'h1, 1'b0, 5'h07);
        applyStimulus(4'h6, 4'h5, 4'hA, 1'b1, 5'h0F);
        waitDrain(40);
        checkOutput("b2b_count", resCyc.size(), 3);
        if (resCyc.size() == 3) begin
            checkOutput("b2b_spacing01", resCyc[1] - resCyc[0], 3);
            checkOutput("b2b_spacing12", resCyc[2] - resCyc[1], 3);
        end

        $display("[TB] fill with stalled output");
        res_ready = 1'b0;
        accepted = 0;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (idx < 7) begin
                in_a = fa[idx]; in_b = fb[idx]; in_c = fc[idx]; in_ctrl = fk[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                expQ.push_back({fk[idx], fq[idx]});
                accepted++;
                idx++;
            end
            tick();
        end
        checkOutput("fill_accepted", accepted, 5);
        checkOutput("fill_in_ready_low", in_ready, 0);
        checkOutput("fill_res_valid", res_valid, 1);
        in_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        checkOutput("fill_in_ready_after_pop", in_ready, 1);
        waitDrain(60);

        $display("[TB] backpressure");
        res_ready = 1'b0;
        applyStimulus(4'hF, 4'h2, 4'hE, 1'b1, 5'h10);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("bp_valid_seen", res_valid, 1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("bp_res_valid", res_valid, 1);
            checkOutput("bp_res_q", res_q, 5'h10);
            checkOutput("bp_res_ctrl", res_ctrl, 1);
            checkOutput("bp_ccta", {ccta_ctrl, ccta_a, ccta_b, ccta_c}, {1'b1, 12'hF2E});
            tick();
        end
        res_ready = 1'b1;
        waitDrain(10);

        $display("[TB] reset mid-apply");
        res_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 4'h1; in_b = 4'h1; in_c = 4'h1; in_ctrl = 1'b0;
        tick();
        in_a = 4'h2; in_b = 4'h2; in_c = 4'h2;
        tick();
        in_a = 4'h3; in_b = 4'h3; in_c = 4'h3;
        tick();
        in_a = 4'h4; in_b = 4'h4; in_c = 4'h4;
        tick();
        in_a = 4'h5; in_b = 4'h5; in_c = 4'h5;
        expQ.push_back({1'b0, 5'h02});
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("mid_busy_before", busy, 1);
        checkOutput("mid_ccta_a_before", ccta_a, 4'h2);
        checkOutput("mid_in_ready_before", in_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_res_valid", res_valid, 0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_in_ready", in_ready, 1);
        checkOutput("mid_ccta", {ccta_ctrl, ccta_a, ccta_b, ccta_c}, 0);
        checkOutput("mid_res_q", res_q, 0);
        expQ.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        checkOutput("mid_no_stale_valid", res_valid, 0);
        checkOutput("mid_no_stale_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/ccta_driver.md
# ccta_driver

Operand sequencer that sits on the input side of the CCTA datapath block. It accepts operand triples (A, B, C, ctrl) from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It presents each triple to the CCTA inputs for a fixed settle window, samples the CCTA 5-bit result `q`, and hands the result downstream over a second valid/ready handshake. It gives the team a clocked, back-pressured way to feed the combinational CCTA from a stream instead of a hand-written stimulus sequence.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- HOLD, 2, cycles each triple is driven before `q` is sampled (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream triple valid
- in_ready  out  1  FIFO can accept (count < DEPTH)
- in_a / in_b / in_c  in  4 each  operand triple
- in_ctrl  in  1  mode bit travelling with triple
- ccta_a / ccta_b / ccta_c  out  4 each  registered drive to CCTA A/B/C
- ccta_ctrl  out  1  registered drive to CCTA ctrl
- ccta_q  in  5  CCTA result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_q  out  5  captured result
- res_ctrl  out  1  ctrl bit of the triple that produced res_q
- busy  out  1  state != IDLE

## Operation
- FIFO: DEPTH×13 bits {ctrl,a,b,c}, wr/rd pointers wrap modulo DEPTH, count 0..DEPTH.
- Push on rising edge when in_valid && in_ready; in_valid while full is ignored (not stored, not an error).
- in_ready = (count != DEPTH), combinational from registered count; full-and-pop in the same cycle still shows in_ready=0.
- FSM states: IDLE, APPLY, OUTPUT.
  - IDLE: if count>0 pop head into ccta_* registers, hold_cnt←HOLD-1, → APPLY.
  - APPLY: if hold_cnt==0 capture res_q←ccta_q, res_ctrl←ccta_ctrl, res_valid←1, → OUTPUT; else hold_cnt−1.
  - OUTPUT: on res_valid && res_ready: res_valid←0; if count>0 pop directly into ccta_* and → APPLY (no bubble), else → IDLE.
- Push and pop in the same edge: count unchanged, both pointers advance.
- ccta_* hold the last applied triple in IDLE/OUTPUT (no glitching to zero between triples).
- res_q/res_ctrl stable while res_valid && !res_ready.
- No arithmetic on data; `q` passed through unmodified at full 5-bit width.

## Timing
- Reset (async assert, sync release at next edge): state=IDLE, count=0, pointers=0, ccta_a/b/c=0, ccta_ctrl=0, res_q=0, res_ctrl=0, res_valid=0, busy=0, in_ready=1.
- Reset mid-operation: all in-flight and buffered triples discarded, outputs to reset values immediately.
- Push at edge k into empty FIFO, FSM IDLE: ccta_* updated at edge k+1; result captured at edge k+1+HOLD; res_valid high after that edge.
- Sustained throughput with res_ready=1: one result per HOLD+1 cycles.
- Stall capacity: with res_ready=0, DEPTH+1 triples accepted before in_ready falls (one in drive registers, DEPTH buffered).
- Results emerge in push order, no reordering or drops.

## Test plan
Bench uses a behavioural CCTA stub: q = A+B when ctrl=0, q = B+C when ctrl=1 (5-bit sum).
- Reset: rst=1 for 2 cycles with in_valid=1 -> nothing stored; all outputs 0, in_ready=1 after release.
- Single triple A=4, B=1, C=9, ctrl=0 pushed at edge 0, HOLD=2, res_ready=1 -> ccta_a=4 after edge 1, res_valid after edge 3 with res_q=5'h05, res_ctrl=0, deasserts next edge.
- Back-to-back: push (3,D,D,0), (5,2,1,0), (6,5,A,1) continuously, res_ready=1 -> res_q 5'h10, 5'h07, 5'h0F in order, spaced 3 cycles.
- Fill: res_ready=0, in_valid held with 7 distinct triples -> exactly 5 accepted, in_ready=0 thereafter; release res_ready -> the 5 results in order, in_ready returns 1 after first pop.
- Backpressure: res_valid=1, res_ready=0 for 6 cycles on (F,2,E,1) -> res_q=5'h10 and res_ctrl=1 stable throughout; ccta_* unchanged.
- Reset mid-APPLY with 3 triples buffered -> res_valid=0, busy=0, count=0, ccta_* =0 immediately; no stale result after release.
